// File: rtl/altera_tse_pma_reset_pkg.sv
// Shared types for the TSE PMA reset sequencer.
// Holds the per-channel state enumeration and the counter-width helper.
package altera_tse_pma_reset_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_PLL  = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } chan_state_e;

    // Width of a counter that must reach max(a, b) - 1.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/altera_tse_pma_rx_reset_channel.sv
// One RX channel: synchronisers, lock/stability FSM and counter.
// Ports: clk, reset_rx_clk (async, active-high), tx_digitalreset_i,
//   rx_freqlocked_i / rx_syncstatus_i (async), rx_digitalreset_o,
//   link_ready_o, retry_pulse_o.
module altera_tse_pma_rx_reset_channel
    import altera_tse_pma_reset_pkg::*;
#(
    parameter int SYNCHRONIZER_DEPTH = 3,
    parameter int LOCK_WAIT_CYCLES   = 1024,
    parameter int STABLE_CYCLES      = 16
) (
    input  logic clk,
    input  logic reset_rx_clk,
    input  logic tx_digitalreset_i,
    input  logic rx_freqlocked_i,
    input  logic rx_syncstatus_i,
    output logic rx_digitalreset_o,
    output logic link_ready_o,
    output logic retry_pulse_o
);

    localparam int CW = cnt_width(LOCK_WAIT_CYCLES, STABLE_CYCLES);
    localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_WAIT_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);

    logic [SYNCHRONIZER_DEPTH-1:0] fl_sync_q;
    logic [SYNCHRONIZER_DEPTH-1:0] ss_sync_q;
    logic                          fl;
    logic                          ss;

    chan_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          retry_d;
    logic          rx_rst_q;
    logic          link_q;
    logic          retry_q;

    assign fl = fl_sync_q[SYNCHRONIZER_DEPTH-1];
    assign ss = ss_sync_q[SYNCHRONIZER_DEPTH-1];

    always_ff @(posedge clk or posedge reset_rx_clk) begin
        if (reset_rx_clk) begin
            fl_sync_q <= '0;
            ss_sync_q <= '0;
        end else begin
            fl_sync_q <= {fl_sync_q[SYNCHRONIZER_DEPTH-2:0], rx_freqlocked_i};
            ss_sync_q <= {ss_sync_q[SYNCHRONIZER_DEPTH-2:0], rx_syncstatus_i};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = 1'b0;
        if (tx_digitalreset_i) begin
            state_d = ST_WAIT_PLL;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_WAIT_PLL: begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
                ST_WAIT_LOCK: begin
                    if (fl) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == LOCK_LAST) begin
                        // Timeout: flag a retry and start a fresh window.
                        retry_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_STABLE: begin
                    // A lock drop outranks reaching the stable count.
                    if (!fl) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_RUN: begin
                    if (!fl) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_WAIT_PLL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset_rx_clk) begin
        if (reset_rx_clk) begin
            state_q  <= ST_WAIT_PLL;
            cnt_q    <= '0;
            rx_rst_q <= 1'b1;
            link_q   <= 1'b0;
            retry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rx_rst_q <= (state_d != ST_RUN);
            link_q   <= (state_d == ST_RUN) & ss;
            retry_q  <= retry_d;
        end
    end

    assign rx_digitalreset_o = rx_rst_q;
    assign link_ready_o      = link_q;
    assign retry_pulse_o     = retry_q;

endmodule

// File: rtl/altera_tse_pma_reset_sequencer.sv
// Multi-channel PMA reset sequencer: shared TX reset, per-channel RX.
// Ports: clk, reset_rx_clk (async, active-high), pll_locked,
//   rx_freqlocked[N], rx_syncstatus[N] in; tx_digitalreset,
//   rx_digitalreset[N], pcs_rx_reset[N], link_ready[N], retry_pulse[N] out.
module altera_tse_pma_reset_sequencer
    import altera_tse_pma_reset_pkg::*;
#(
    parameter int NUM_CHANNELS       = 4,
    parameter int SYNCHRONIZER_DEPTH = 3,
    parameter int LOCK_WAIT_CYCLES   = 1024,
    parameter int STABLE_CYCLES      = 16
) (
    input  logic                    clk,
    input  logic                    reset_rx_clk,
    input  logic                    pll_locked,
    input  logic [NUM_CHANNELS-1:0] rx_freqlocked,
    input  logic [NUM_CHANNELS-1:0] rx_syncstatus,
    output logic                    tx_digitalreset,
    output logic [NUM_CHANNELS-1:0] rx_digitalreset,
    output logic [NUM_CHANNELS-1:0] pcs_rx_reset,
    output logic [NUM_CHANNELS-1:0] link_ready,
    output logic [NUM_CHANNELS-1:0] retry_pulse
);

    logic [SYNCHRONIZER_DEPTH-1:0] rst_pipe_q;
    logic [SYNCHRONIZER_DEPTH-1:0] pll_sync_q;
    logic                          tx_rst_q;

    // Reset asserts at once; release ripples through a chain of 1s.
    always_ff @(posedge clk or posedge reset_rx_clk) begin
        if (reset_rx_clk) begin
            rst_pipe_q <= '1;
            pll_sync_q <= '0;
            tx_rst_q   <= 1'b1;
        end else begin
            rst_pipe_q <= {rst_pipe_q[SYNCHRONIZER_DEPTH-2:0], 1'b0};
            pll_sync_q <= {pll_sync_q[SYNCHRONIZER_DEPTH-2:0], pll_locked};
            tx_rst_q   <= rst_pipe_q[SYNCHRONIZER_DEPTH-1]
                        | ~pll_sync_q[SYNCHRONIZER_DEPTH-1];
        end
    end

    assign tx_digitalreset = tx_rst_q;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        altera_tse_pma_rx_reset_channel #(
            .SYNCHRONIZER_DEPTH (SYNCHRONIZER_DEPTH),
            .LOCK_WAIT_CYCLES   (LOCK_WAIT_CYCLES),
            .STABLE_CYCLES      (STABLE_CYCLES)
        ) u_ch (
            .clk               (clk),
            .reset_rx_clk      (reset_rx_clk),
            .tx_digitalreset_i (tx_rst_q),
            .rx_freqlocked_i   (rx_freqlocked[i]),
            .rx_syncstatus_i   (rx_syncstatus[i]),
            .rx_digitalreset_o (rx_digitalreset[i]),
            .link_ready_o      (link_ready[i]),
            .retry_pulse_o     (retry_pulse[i])
        );
    end

    assign pcs_rx_reset = rx_digitalreset;

endmodule

// File: tb/tb_altera_tse_pma_reset_sequencer.sv
// Bench for altera_tse_pma_reset_sequencer: cycle model plus
// directed scenarios with hand-derived edge numbers.
module tb_altera_tse_pma_reset_sequencer;

    localparam int N = 4;
    localparam int D = 3;
    localparam int L = 16;
    localparam int S = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         pll = 1'b1;
    logic [N-1:0] fl  = '1;
    logic [N-1:0] ss  = '0;
    logic         tx;
    logic [N-1:0] rx, pcs, link, retry;

    int vectors     = 0;
    int miscompares = 0;
    int edge_n      = 0;
    int ret2[$];

    altera_tse_pma_reset_sequencer #(
        .NUM_CHANNELS       (N),
        .SYNCHRONIZER_DEPTH (D),
        .LOCK_WAIT_CYCLES   (L),
        .STABLE_CYCLES      (S)
    ) dut (
        .clk             (clk),
        .reset_rx_clk    (rst),
        .pll_locked      (pll),
        .rx_freqlocked   (fl),
        .rx_syncstatus   (ss),
        .tx_digitalreset (tx),
        .rx_digitalreset (rx),
        .pcs_rx_reset    (pcs),
        .link_ready      (link),
        .retry_pulse     (retry)
    );

    always #5 clk = ~clk;

    // Model: inputs seen D edges late; a channel runs once its
    // synchronised lock has been high on S+1 edges since it left reset.
    logic         m_tx = 1'b1;
    logic [N-1:0] m_rx = '1;
    logic [N-1:0] m_link = '0;
    logic [N-1:0] m_retry = '0;
    int           m_rel = 0;
    logic         pll_h [D];
    logic [N-1:0] fl_h [D];
    logic [N-1:0] ss_h [D];
    bit           act [N];
    int           streak [N];
    int           w [N];

    task automatic model_reset();
        m_tx = 1'b1; m_rx = '1; m_link = '0; m_retry = '0;
        m_rel = 0;
        for (int i = 0; i < D; i++) begin
            pll_h[i] = 1'b0; fl_h[i] = '0; ss_h[i] = '0;
        end
        for (int c = 0; c < N; c++) begin
            act[c] = 1'b0; streak[c] = 0; w[c] = 0;
        end
    endtask

    task automatic model_step();
        logic         tx_b, pll_s;
        logic [N-1:0] fl_s, ss_s;
        bit           run;
        tx_b  = m_tx;
        pll_s = pll_h[D-1];
        fl_s  = fl_h[D-1];
        ss_s  = ss_h[D-1];
        m_tx  = (m_rel < D) || !pll_s;
        for (int c = 0; c < N; c++) begin
            m_retry[c] = 1'b0;
            if (tx_b) begin
                act[c] = 1'b0; streak[c] = 0; w[c] = 0;
            end else if (!act[c]) begin
                act[c] = 1'b1; streak[c] = 0; w[c] = 0;
            end else if (fl_s[c]) begin
                if (streak[c] <= S) streak[c]++;
                w[c] = 0;
            end else if (streak[c] > 0) begin
                streak[c] = 0; w[c] = 0;
            end else begin
                w[c]++;
                if (w[c] == L) begin
                    m_retry[c] = 1'b1; w[c] = 0;
                end
            end
            run = (streak[c] >= S + 1);
            m_rx[c]   = !run;
            m_link[c] = run && ss_s[c];
        end
        for (int i = D - 1; i > 0; i--) begin
            pll_h[i] = pll_h[i-1]; fl_h[i] = fl_h[i-1]; ss_h[i] = ss_h[i-1];
        end
        pll_h[0] = pll; fl_h[0] = fl; ss_h[0] = ss;
        if (m_rel < D) m_rel++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_reset();
                edge_n = 0;
            end else begin
                model_step();
                edge_n++;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        vectors++;
        if ({tx, rx, pcs, link, retry} !== {m_tx, m_rx, m_rx, m_link, m_retry}) begin
            miscompares++;
            $display("FAIL model edge=%0d tx=%b/%b rx=%b/%b pcs=%b link=%b/%b retry=%b/%b",
                     edge_n, tx, m_tx, rx, m_rx, pcs, link, m_link, retry, m_retry);
        end
        if (retry[2]) ret2.push_back(edge_n);
    end

    task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
        vectors++;
        if (act_v !== exp_v) begin
            miscompares++;
            $display("FAIL %s got=%0h required=%0h", nm, act_v, exp_v);
        end
    endtask

    task automatic to_edge(input int n);
        int g;
        g = 0;
        while (edge_n < n && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (edge_n < n) begin
            vectors++;
            miscompares++;
            $display("FAIL to_edge got=%0d required=%0d", edge_n, n);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_rx", 32'(rx), 32'hF);
        chk("rst_link", 32'(link), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;

        // Bring-up with channel 2 unlocked for 40 cycles.
        pll = 1'b1; fl = 4'b1011; ss = '0;
        do_reset();
        ret2.delete();
        to_edge(3);  chk("tx_e3", 32'(tx), 32'd1);
        to_edge(4);  chk("tx_e4", 32'(tx), 32'd0);
        to_edge(13); chk("rx_e13", 32'(rx), 32'hF);
        to_edge(14); chk("rx_e14", 32'(rx), 32'h4);
        to_edge(20); ss = '1;
        to_edge(23); chk("link_e23", 32'(link), 32'd0);
        to_edge(24); chk("link_e24", 32'(link), 32'hB);
        to_edge(40); fl = '1;
        to_edge(51); chk("rx2_e51", 32'(rx), 32'h4);
        to_edge(52); chk("rx2_e52", 32'(rx), 32'h0);
        chk("retry2_cnt", 32'(ret2.size()), 32'd2);
        if (ret2.size() == 2) begin
            chk("retry2_a", 32'(ret2[0]), 32'd21);
            chk("retry2_b", 32'(ret2[1]), 32'd37);
        end
        // Channel 0 sync status toggle while running.
        to_edge(60); ss[0] = 1'b0;
        to_edge(63); chk("link0_e63", 32'(link), 32'hF);
        to_edge(64); chk("link0_e64", 32'(link), 32'hE);
        chk("rx_e64", 32'(rx), 32'h0);
        to_edge(66); ss[0] = 1'b1;
        to_edge(70); chk("link0_e70", 32'(link), 32'hF);

        // One-cycle lock glitch on channel 1 in STABLE, then PLL loss.
        fl = '1; ss = '1;
        do_reset();
        to_edge(8);  fl[1] = 1'b0;
        to_edge(9);  fl[1] = 1'b1;
        to_edge(14); chk("g_rx_e14", 32'(rx), 32'h2);
        to_edge(20); chk("g_rx_e20", 32'(rx), 32'h2);
        to_edge(21); chk("g_rx_e21", 32'(rx), 32'h0);
        to_edge(40); pll = 1'b0;
        to_edge(43); chk("p_tx_e43", 32'(tx), 32'd0);
        to_edge(44); chk("p_tx_e44", 32'(tx), 32'd1);
        chk("p_rx_e44", 32'(rx), 32'h0);
        to_edge(45); chk("p_rx_e45", 32'(rx), 32'hF);
        to_edge(50); pll = 1'b1;
        to_edge(53); chk("r_tx_e53", 32'(tx), 32'd1);
        to_edge(54); chk("r_tx_e54", 32'(tx), 32'd0);
        to_edge(63); chk("r_rx_e63", 32'(rx), 32'hF);
        to_edge(64); chk("r_rx_e64", 32'(rx), 32'h0);

        // Asynchronous reset in the middle of STABLE.
        do_reset();
        to_edge(9);
        #2 rst = 1'b1;
        #1;
        chk("ar_tx", 32'(tx), 32'd1);
        chk("ar_rx", 32'(rx), 32'hF);
        chk("ar_pcs", 32'(pcs), 32'hF);
        chk("ar_link", 32'(link), 32'd0);
        chk("ar_retry", 32'(retry), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        to_edge(30);
        chk("ar_rx_e30", 32'(rx), 32'h0);
        chk("ar_link_e30", 32'(link), 32'hF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
